// File: rtl/muldiv_unit.sv
// Iterative radix-2 MIPS multiply/divide unit with architectural HI/LO.
// One operand bit is consumed per cycle; signed operations run on magnitudes
// and the sign is restored in a single fix-up cycle that also writes HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;       // negate product / quotient
    logic               rneg_q, rneg_d;     // negate remainder (dividend sign)
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   orig_q, orig_d;     // original rs_data for divide-by-zero
    logic [WIDTH-1:0]   b_q, b_d;           // multiplicand / divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;       // product accumulator; low half = dividend/quotient
    logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand magnitudes at launch; op[0]==0 selects the signed variants.
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & rs_data[WIDTH-1];
    assign b_neg     = signed_op & rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;

    // One shift-add multiply step: add multiplicand into the upper half when
    // the current multiplier bit is set, then shift the whole accumulator right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step on a WIDTH+1-bit shifted remainder.
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_acc;

    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_acc   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};

    // Sign fix-up of the finished magnitudes.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -rem_q : rem_q;

    // Next-state logic for the control FSM, datapath and HI/LO.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        orig_d   = orig_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // start has priority over a simultaneous mthi/mtlo
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    div0_d   = op[1] & (rt_data == '0);
                    orig_d   = rs_data;
                    b_d      = b_mag;
                    acc_d    = {{WIDTH{1'b0}}, a_mag};
                    rem_d    = '0;
                end else begin
                    if (mthi) hi_d = rs_data;
                    if (mtlo) lo_d = rs_data;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = is_div_q ? div_acc : mul_acc;
                rem_d = is_div_q ? div_rem : rem_q;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = orig_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            orig_q   <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            orig_q   <= orig_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an arithmetic reference model predicts HI/LO/busy/done
// every cycle, and directed vectors pin the model with literal results.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        logic [31:0] q, r;
        model_res = '0;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                model_res = sp;
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                model_res = up;
            end
            2'b10: begin
                if (b == 0) model_res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_res = {32'h0, a};
                else begin
                    sa = a;
                    sb = b;
                    q = sa / sb;
                    r = sa % sb;
                    model_res = {r, q};
                end
            end
            default: begin
                if (b == 0) model_res = {a, 32'hFFFF_FFFF};
                else model_res = {a % b, a / b};
            end
        endcase
    endfunction

    // Reference model: remaining edges until done, plus pending result.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_cnt;
    logic        m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0; m_pend = '0;
        end else begin
            m_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_pend = model_res(op, rs_data, rt_data);
                m_cnt  = 33;
            end else begin
                if (mthi) m_hi = rs_data;
                if (mtlo) m_lo = rs_data;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("cyc_busy", busy, (m_cnt != 0));
            check("cyc_done", done, m_done);
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    // Waits for done; n counts edges since the accepting edge.
    task automatic wait_done(input int n0, output int n, output bit got, output bit all_busy);
        n = n0;
        got = 1'b0;
        all_busy = 1'b1;
        while (!got && n <= 40) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                if (!busy) all_busy = 1'b0;
                n++;
            end
        end
    endtask

    task automatic run_op(input bit b2b, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input string nm);
        int n;
        bit got, all_busy;
        if (!b2b) @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
        wait_done(1, n, got, all_busy);
        check({nm, "_done_seen"}, got, 1'b1);
        if (got) begin
            check({nm, "_latency"}, n, 33);
            check({nm, "_busy_during"}, all_busy, 1'b1);
            check({nm, "_busy_at_done"}, busy, 1'b0);
            check({nm, "_hi"}, hi, eh);
            check({nm, "_lo"}, lo, el);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  got, all_busy;
        rst = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        mthi = 1'b0; mtlo = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;

        run_op(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
        // next start accepted in the cycle done is high
        run_op(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
        run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_minneg");
        run_op(1'b0, 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0");
        run_op(1'b0, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, "div_7dm2");
        run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7d0");
        run_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, "divu_big");
        run_op(1'b0, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, "mult_extremes");

        // start and mtlo while busy are ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_data = 32'd6; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b11; rs_data = 32'd9; rt_data = 32'd3; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        wait_done(6, n, got, all_busy);
        check("ign_done_seen", got, 1'b1);
        check("ign_latency", n, 33);
        check("ign_hi", hi, 32'h0);
        check("ign_lo", lo, 32'd42);

        // mthi when idle: visible one edge later, no done pulse
        @(negedge clk);
        mthi = 1'b1; rs_data = 32'h1234;
        @(posedge clk);
        #1;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_done", done, 1'b0);
        @(negedge clk);
        mthi = 1'b0;

        // mthi and mtlo together write both
        mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hA5A5;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mtboth_hi", hi, 32'hA5A5);
        check("mtboth_lo", lo, 32'hA5A5);

        // start wins over a simultaneous mthi
        start = 1'b1; mthi = 1'b1; op = 2'b01; rs_data = 32'd1; rt_data = 32'd1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("startwin_hi_held", hi, 32'hA5A5);
        check("startwin_busy", busy, 1'b1);
        wait_done(1, n, got, all_busy);
        check("startwin_done_seen", got, 1'b1);
        check("startwin_hi", hi, 32'h0);
        check("startwin_lo", lo, 32'h1);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 2'b10; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run_op(1'b0, 2'b01, 32'd2, 32'd3, 32'h0, 32'd6, "multu_after_rst");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
